alu_issue_ctrl: RTL and testbench

Registered, parametrised successor to the combinational opcode-to-ALU-op decoder. It sits between decode and execute. It accepts one opcode per valid/ready handshake and produces a registered ALU control word with immediate, memory and compare qualifiers. It also holds issue for the programmed latency of multi-cycle MUL/DIV operations and flags unknown opcodes instead of latching stale outputs.

---
 rtl/alu_issue_ctrl_if.sv | 28 ++
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Handshake and control-word bundle between decode, the issue controller and execute.
// The slave side is the issue controller; the master side is decode plus execute.
interface alu_issue_ctrl_if #(
    parameter int OPW  = 5,
    parameter int AOPW = 3
);
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  opcode;
    logic            out_valid;
    logic            out_ready;
    logic [AOPW-1:0] aluOP;
    logic            imm_sel;
    logic [1:0]      mem_op;
    logic            cmp_only;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, opcode, out_ready,
        input  in_ready, out_valid, aluOP, imm_sel, mem_op, cmp_only, illegal, busy
    );

    modport slave (
        input  in_valid, opcode, out_ready,
        output in_ready, out_valid, aluOP, imm_sel, mem_op, cmp_only, illegal, busy
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Registered opcode-to-ALU-control issue stage with valid/ready handshake and
// a hold-off down-counter for multi-cycle MUL/DIV.
module alu_issue_ctrl #(
    parameter int OPW     = 5,
    parameter int AOPW    = 3,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    alu_issue_ctrl_if.slave bus
);
    // state | meaning
    // IDLE  | no control word held
    // WAIT  | MUL/DIV counting down, issue held
    // OUT   | control word valid toward execute
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, OUT = 2'd2} state_t;

    localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNTW   = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

    localparam logic [AOPW-1:0] ALU_ADD = AOPW'(3'b000);
    localparam logic [AOPW-1:0] ALU_SUB = AOPW'(3'b001);
    localparam logic [AOPW-1:0] ALU_MUL = AOPW'(3'b010);
    localparam logic [AOPW-1:0] ALU_DIV = AOPW'(3'b011);
    localparam logic [AOPW-1:0] ALU_AND = AOPW'(3'b100);
    localparam logic [AOPW-1:0] ALU_OR  = AOPW'(3'b101);
    localparam logic [AOPW-1:0] ALU_XOR = AOPW'(3'b110);
    localparam logic [AOPW-1:0] ALU_NOT = AOPW'(3'b111);

    state_t          state;
    logic [CNTW-1:0] cnt;

    logic [AOPW-1:0] dec_alu;
    logic            dec_imm;
    logic [1:0]      dec_mem;
    logic            dec_cmp;
    logic            dec_ill;
    logic            dec_mul;
    logic            dec_div;
    logic            accept;

    always_comb begin
        dec_alu = ALU_ADD;
        dec_imm = 1'b0;
        dec_mem = 2'b00;
        dec_cmp = 1'b0;
        dec_ill = 1'b0;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        case (bus.opcode[4:0])
            5'b00010: dec_alu = ALU_ADD;
            5'b00011: begin dec_alu = ALU_ADD; dec_imm = 1'b1; end
            5'b00100: dec_alu = ALU_SUB;
            5'b00101: begin dec_alu = ALU_SUB; dec_imm = 1'b1; end
            5'b00110: begin dec_alu = ALU_MUL; dec_mul = 1'b1; end
            5'b00111: begin dec_alu = ALU_AND; dec_imm = 1'b1; end
            5'b01000: begin dec_alu = ALU_DIV; dec_div = 1'b1; end
            5'b01010: dec_alu = ALU_AND;
            5'b01011: begin dec_alu = ALU_AND; dec_imm = 1'b1; end
            5'b01100: dec_alu = ALU_OR;
            5'b01101: begin dec_alu = ALU_OR; dec_imm = 1'b1; end
            5'b01110: dec_alu = ALU_NOT;
            5'b10000: dec_alu = ALU_XOR;
            5'b10001: begin dec_alu = ALU_XOR; dec_imm = 1'b1; end
            5'b10010: begin dec_alu = ALU_SUB; dec_cmp = 1'b1; end
            5'b11100: begin dec_alu = ALU_ADD; dec_imm = 1'b1; dec_mem = 2'b10; end
            5'b11101: begin dec_alu = ALU_ADD; dec_imm = 1'b1; dec_mem = 2'b01; end
            5'b11110: begin dec_alu = ALU_AND; dec_imm = 1'b1; end
            default:  dec_ill = 1'b1;
        endcase
        // Opcode bits above the decoded five make the whole op illegal.
        if ((bus.opcode >> 5) != '0) begin
            dec_alu = ALU_ADD;
            dec_imm = 1'b0;
            dec_mem = 2'b00;
            dec_cmp = 1'b0;
            dec_mul = 1'b0;
            dec_div = 1'b0;
            dec_ill = 1'b1;
        end
    end

    always_comb begin
        case (state)
            IDLE:    bus.in_ready = ~flush;
            OUT:     bus.in_ready = bus.out_ready & ~flush;
            default: bus.in_ready = 1'b0;
        endcase
    end

    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.aluOP     <= '0;
            bus.imm_sel   <= 1'b0;
            bus.mem_op    <= 2'b00;
            bus.cmp_only  <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (cnt == '0) begin
                        state         <= OUT;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        bus.aluOP    <= dec_alu;
                        bus.imm_sel  <= dec_imm;
                        bus.mem_op   <= dec_mem;
                        bus.cmp_only <= dec_cmp;
                        bus.illegal  <= dec_ill;
                        // A latency of one needs no countdown: straight to OUT.
                        if (dec_mul && MUL_LAT > 1) begin
                            state         <= WAIT;
                            cnt           <= CNTW'(MUL_LAT - 1);
                            bus.busy      <= 1'b1;
                            bus.out_valid <= 1'b0;
                        end else if (dec_div && DIV_LAT > 1) begin
                            state         <= WAIT;
                            cnt           <= CNTW'(DIV_LAT - 1);
                            bus.busy      <= 1'b1;
                            bus.out_valid <= 1'b0;
                        end else begin
                            state         <= OUT;
                            bus.busy      <= 1'b0;
                            bus.out_valid <= 1'b1;
                        end
                    end else if (state == IDLE || bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: cycle-level model compared every cycle on the main
// instance, plus literal expectations on a MUL_LAT=1 second instance.
module tb_alu_issue_ctrl;
    localparam int MUL_A = 3;
    localparam int DIV_A = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.OPW(6), .AOPW(3)) ia ();
    alu_issue_ctrl_if #(.OPW(5), .AOPW(3)) ib ();

    alu_issue_ctrl #(.OPW(6), .AOPW(3), .MUL_LAT(MUL_A), .DIV_LAT(DIV_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ia.slave)
    );
    alu_issue_ctrl #(.OPW(5), .AOPW(3), .MUL_LAT(1), .DIV_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ib.slave)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       ill;
        logic [2:0] alu;
        logic       imm;
        logic [1:0] mem;
        logic       cmp;
        int         lat;
    } word_t;

    function automatic word_t decode(input logic [5:0] op);
        word_t w;
        w = '{ill: 1'b0, alu: 3'd0, imm: 1'b0, mem: 2'b00, cmp: 1'b0, lat: 1};
        case (op)
            6'd2:  ;
            6'd3:  w.imm = 1;
            6'd4:  w.alu = 3'd1;
            6'd5:  begin w.alu = 3'd1; w.imm = 1; end
            6'd6:  begin w.alu = 3'd2; w.lat = MUL_A; end
            6'd7:  begin w.alu = 3'd4; w.imm = 1; end
            6'd8:  begin w.alu = 3'd3; w.lat = DIV_A; end
            6'd10: w.alu = 3'd4;
            6'd11: begin w.alu = 3'd4; w.imm = 1; end
            6'd12: w.alu = 3'd5;
            6'd13: begin w.alu = 3'd5; w.imm = 1; end
            6'd14: w.alu = 3'd7;
            6'd16: w.alu = 3'd6;
            6'd17: begin w.alu = 3'd6; w.imm = 1; end
            6'd18: begin w.alu = 3'd1; w.cmp = 1; end
            6'd28: begin w.imm = 1; w.mem = 2'b10; end
            6'd29: begin w.imm = 1; w.mem = 2'b01; end
            6'd30: begin w.alu = 3'd4; w.imm = 1; end
            default: w.ill = 1;
        endcase
        return w;
    endfunction

    // Model: a held word, whether it is visible, and the edge number it becomes due.
    word_t m_word;
    logic  m_valid = 1'b0;
    logic  m_busy = 1'b0;
    logic  m_acc = 1'b0;
    int    m_due = 0;
    int    edge_no = 0;

    function automatic logic model_ready();
        return !flush && !m_busy && (!m_valid || ia.out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_acc   = 1'b0;
            m_word  = '{ill: 1'b0, alu: 3'd0, imm: 1'b0, mem: 2'b00, cmp: 1'b0, lat: 1};
        end else begin
            logic rdy;
            edge_no++;
            rdy   = model_ready();
            m_acc = 1'b0;
            if (flush) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end else begin
                if (m_busy && edge_no == m_due) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                end else if (m_valid && ia.out_ready) begin
                    m_valid = 1'b0;
                end
                if (ia.in_valid && rdy) begin
                    m_acc  = 1'b1;
                    m_word = decode(ia.opcode);
                    if (m_word.lat == 1) begin
                        m_valid = 1'b1;
                    end else begin
                        m_busy = 1'b1;
                        m_due  = edge_no + m_word.lat;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  int'(ia.in_ready),  int'(model_ready()));
        chk("out_valid", int'(ia.out_valid), int'(m_valid));
        chk("busy",      int'(ia.busy),      int'(m_busy));
        chk("aluOP",     int'(ia.aluOP),     int'(m_word.alu));
        chk("imm_sel",   int'(ia.imm_sel),   int'(m_word.imm));
        chk("mem_op",    int'(ia.mem_op),    int'(m_word.mem));
        chk("cmp_only",  int'(ia.cmp_only),  int'(m_word.cmp));
        chk("illegal",   int'(ia.illegal),   int'(m_word.ill));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ia.in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_op(input logic [5:0] op);
        ia.opcode   = op;
        ia.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_acc) break;
        end
        if (!m_acc) chk("accept_timeout", 0, 1);
    endtask

    // Returns the sample index (1-based after the accept sample) of first out_valid and busy count.
    task automatic watch(input int n, output int first, output int nbusy);
        first = 0;
        nbusy = int'(ia.busy);
        for (int i = 1; i <= n; i++) begin
            step();
            if (ia.out_valid && first == 0) first = i;
            nbusy += int'(ia.busy);
        end
    endtask

    initial begin
        int first;
        int nbusy;
        ia.in_valid  = 1'b1;
        ia.opcode    = 6'b000011;
        ia.out_ready = 1'b1;
        ib.in_valid  = 1'b0;
        ib.opcode    = 5'b0;
        ib.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(ia.out_valid), 0);
        chk("rst_busy",      int'(ia.busy), 0);
        chk("rst_in_ready",  int'(ia.in_ready), 1);
        chk("rst_aluOP",     int'(ia.aluOP), 0);
        ia.in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        send_op(6'b000011);
        chk("addi_aluOP", int'(ia.aluOP), 0);
        chk("addi_imm",   int'(ia.imm_sel), 1);
        chk("addi_valid", int'(ia.out_valid), 1);
        idle(2);

        send_op(6'b000100);
        chk("b2b_sub_alu", int'(ia.aluOP), 1);
        send_op(6'b010010);
        chk("b2b_cmp_alu", int'(ia.aluOP), 1);
        chk("b2b_cmp_flag", int'(ia.cmp_only), 1);
        send_op(6'b011101);
        chk("b2b_ld_mem", int'(ia.mem_op), 1);
        send_op(6'b011100);
        chk("b2b_st_mem", int'(ia.mem_op), 2);
        chk("b2b_st_valid", int'(ia.out_valid), 1);
        idle(2);

        ia.out_ready = 1'b0;
        send_op(6'b010000);
        ia.opcode = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_aluOP", int'(ia.aluOP), 6);
            chk("bp_in_ready", int'(ia.in_ready), 0);
            chk("bp_valid", int'(ia.out_valid), 1);
        end
        ia.out_ready = 1'b1;
        step();
        chk("bp_next_aluOP", int'(ia.aluOP), 0);
        idle(2);

        send_op(6'b001000);
        ia.in_valid = 1'b0;
        watch(20, first, nbusy);
        chk("div_latency", first, 16);
        chk("div_busy_cycles", nbusy, 16);
        idle(1);
        send_op(6'b000110);
        ia.in_valid = 1'b0;
        watch(6, first, nbusy);
        chk("mul_latency", first, 3);
        chk("mul_busy_cycles", nbusy, 3);
        idle(1);

        send_op(6'b011111);
        chk("ill5_flag", int'(ia.illegal), 1);
        chk("ill5_alu", int'(ia.aluOP), 0);
        send_op(6'b100010);
        chk("ill6_flag", int'(ia.illegal), 1);
        chk("ill6_valid", int'(ia.out_valid), 1);
        idle(2);

        send_op(6'b001000);
        ia.in_valid = 1'b0;
        repeat (8) step();
        flush       = 1'b1;
        ia.in_valid = 1'b1;
        ia.opcode   = 6'b000010;
        step();
        flush       = 1'b0;
        ia.in_valid = 1'b0;
        chk("flush_busy", int'(ia.busy), 0);
        watch(20, first, nbusy);
        chk("flush_no_valid", first, 0);
        idle(1);

        send_op(6'b001000);
        ia.in_valid = 1'b0;
        repeat (8) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(ia.busy), 0);
        chk("arst_valid", int'(ia.out_valid), 0);
        #2 rst_n = 1'b1;
        watch(20, first, nbusy);
        chk("arst_no_valid", first, 0);
        chk("arst_no_busy", nbusy, 0);

        ib.opcode   = 5'b00110;
        ib.in_valid = 1'b1;
        step();
        ib.in_valid = 1'b0;
        chk("b_mul_valid", int'(ib.out_valid), 1);
        chk("b_mul_busy", int'(ib.busy), 0);
        chk("b_mul_alu", int'(ib.aluOP), 2);
        step();
        ib.opcode   = 5'b01000;
        ib.in_valid = 1'b1;
        step();
        ib.in_valid = 1'b0;
        chk("b_div_busy0", int'(ib.busy), 1);
        step();
        chk("b_div_busy1", int'(ib.busy), 1);
        chk("b_div_valid1", int'(ib.out_valid), 0);
        step();
        chk("b_div_valid2", int'(ib.out_valid), 1);
        chk("b_div_busy2", int'(ib.busy), 0);
        chk("b_div_alu", int'(ib.aluOP), 3);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
